// File: rtl/dp_seq_pkg.sv
// Shared types and constants for the datapath sequencer: FSM states, instruction
// classes, IR field layout and the registered control bundle.
package dp_seq_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned IW = 16;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_RD  = 3'd5,
    S_WR_IMM = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    INS_ILLEGAL = 3'd0,
    INS_MOV_IMM = 3'd1,
    INS_MOV_REG = 3'd2,
    INS_ADD     = 3'd3,
    INS_CMP     = 3'd4,
    INS_AND     = 3'd5,
    INS_MVN     = 3'd6
  } ins_e;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn;
    logic [RW-1:0] rd;
    logic [1:0]    sh;
    logic [RW-1:0] rm;
  } instr_t;

  typedef struct packed {
    logic          w;
    logic [RW-1:0] readnum;
    logic          loada;
    logic          loadb;
    logic [1:0]    shift;
    logic          asel;
    logic          bsel;
    logic [1:0]    aluop;
    logic          loadc;
    logic          loads;
    logic [RW-1:0] writenum;
    logic          vsel;
    logic          write;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{w: 1'b1, default: '0};

endpackage

// File: rtl/dp_seq_decode.sv
// Combinational IR decode: field split, imm8 sign-extension and instruction class.
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  logic [IW-1:0] i_ir,
  output logic [RW-1:0] o_rn_c,
  output logic [RW-1:0] o_rd_c,
  output logic [RW-1:0] o_rm_c,
  output logic [1:0]    o_sh_c,
  output logic [1:0]    o_op_c,
  output logic [DW-1:0] o_sximm8_c,
  output logic [2:0]    o_cls_c
);

  instr_t w_f;
  ins_e   w_cls;

  assign w_f        = instr_t'(i_ir);
  assign o_rn_c     = w_f.rn;
  assign o_rd_c     = w_f.rd;
  assign o_rm_c     = w_f.rm;
  assign o_sh_c     = w_f.sh;
  assign o_op_c     = w_f.op;
  assign o_sximm8_c = {{(DW-8){i_ir[7]}}, i_ir[7:0]};
  assign o_cls_c    = w_cls;

  // Anything outside the six recognised opcode/op pairs is illegal
  always_comb begin
    w_cls = INS_ILLEGAL;
    if (w_f.opcode == OPC_MOV) begin
      if (w_f.op == OP_MOV_IMM)      w_cls = INS_MOV_IMM;
      else if (w_f.op == OP_MOV_REG) w_cls = INS_MOV_REG;
    end else if (w_f.opcode == OPC_ALU) begin
      case (w_f.op)
        OP_ADD:  w_cls = INS_ADD;
        OP_CMP:  w_cls = INS_CMP;
        OP_AND:  w_cls = INS_AND;
        OP_MVN:  w_cls = INS_MVN;
        default: w_cls = INS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle controller driving the register/shift/ALU datapath from a latched IR.
// Optional macro DP_SEQ_ILLEGAL_FLAG_EN adds a sticky ill_op output.
module dp_sequencer
  import dp_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [IW-1:0] instr_in,
  input  logic          s,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic          loada,
  output logic          loadb,
  output logic [1:0]    shift,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads,
  output logic [RW-1:0] writenum,
  output logic          vsel,
  output logic          write,
  output logic [DW-1:0] datapath_in
`ifdef DP_SEQ_ILLEGAL_FLAG_EN
  ,
  output logic          ill_op
`endif
);

  state_e        r_state;
  state_e        w_next_state;
  logic [IW-1:0] r_ir;
  logic          w_ir_load;
  ctrl_t         r_ctrl;
  ctrl_t         w_ctrl_next;

  logic [RW-1:0] w_rn;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rm;
  logic [1:0]    w_sh;
  logic [1:0]    w_op;
  logic [DW-1:0] w_sximm8;
  logic [2:0]    w_cls_raw;
  ins_e          w_cls;

  dp_seq_decode u_decode (
    .i_ir       (r_ir),
    .o_rn_c     (w_rn),
    .o_rd_c     (w_rd),
    .o_rm_c     (w_rm),
    .o_sh_c     (w_sh),
    .o_op_c     (w_op),
    .o_sximm8_c (w_sximm8),
    .o_cls_c    (w_cls_raw)
  );

  assign w_cls = ins_e'(w_cls_raw);

  // Controls are registered from the next state; the IR cannot change outside
  // WAIT, so decoding it now gives the same fields the next state will see.
  always_comb begin
    w_next_state = r_state;
    w_ir_load    = 1'b0;
    w_ctrl_next  = '0;

    case (r_state)
      S_WAIT: begin
        w_ir_load = load;
        if (s) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        case (w_cls)
          INS_MOV_IMM:                 w_next_state = S_WR_IMM;
          INS_MOV_REG, INS_MVN:        w_next_state = S_GET_B;
          INS_ADD, INS_CMP, INS_AND:   w_next_state = S_GET_A;
          default:                     w_next_state = S_WAIT;
        endcase
      end
      S_GET_A:  w_next_state = S_GET_B;
      S_GET_B:  w_next_state = S_EXEC;
      S_EXEC:   w_next_state = (w_cls == INS_CMP) ? S_WAIT : S_WR_RD;
      S_WR_RD:  w_next_state = S_WAIT;
      S_WR_IMM: w_next_state = S_WAIT;
      default:  w_next_state = S_WAIT;
    endcase

    case (w_next_state)
      S_WAIT: w_ctrl_next.w = 1'b1;
      S_GET_A: begin
        w_ctrl_next.readnum = w_rn;
        w_ctrl_next.loada   = 1'b1;
      end
      S_GET_B: begin
        w_ctrl_next.readnum = w_rm;
        w_ctrl_next.loadb   = 1'b1;
      end
      S_EXEC: begin
        w_ctrl_next.shift = w_sh;
        if (w_cls == INS_MOV_REG) begin
          w_ctrl_next.asel  = 1'b1;
          w_ctrl_next.aluop = ALU_ADD;
        end else begin
          w_ctrl_next.aluop = w_op;
        end
        if (w_cls == INS_CMP) w_ctrl_next.loads = 1'b1;
        else                  w_ctrl_next.loadc = 1'b1;
      end
      S_WR_RD: begin
        w_ctrl_next.writenum = w_rd;
        w_ctrl_next.write    = 1'b1;
      end
      S_WR_IMM: begin
        w_ctrl_next.writenum = w_rn;
        w_ctrl_next.vsel     = 1'b1;
        w_ctrl_next.write    = 1'b1;
      end
      default: w_ctrl_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
      r_ctrl  <= CTRL_IDLE;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= w_ctrl_next;
      if (w_ir_load) r_ir <= instr_in;
    end
  end

`ifdef DP_SEQ_ILLEGAL_FLAG_EN
  logic r_ill;

  // Sticky until a fresh load in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill <= 1'b0;
    end else if (w_ir_load) begin
      r_ill <= 1'b0;
    end else if (r_state == S_DECODE && w_cls == INS_ILLEGAL) begin
      r_ill <= 1'b1;
    end
  end

  assign ill_op = r_ill;
`endif

  assign w           = r_ctrl.w;
  assign readnum     = r_ctrl.readnum;
  assign loada       = r_ctrl.loada;
  assign loadb       = r_ctrl.loadb;
  assign shift       = r_ctrl.shift;
  assign asel        = r_ctrl.asel;
  assign bsel        = r_ctrl.bsel;
  assign ALUop       = r_ctrl.aluop;
  assign loadc       = r_ctrl.loadc;
  assign loads       = r_ctrl.loads;
  assign writenum    = r_ctrl.writenum;
  assign vsel        = r_ctrl.vsel;
  assign write       = r_ctrl.write;
  assign datapath_in = w_sximm8;

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed scenarios plus random instructions
// compared cycle by cycle against a per-mnemonic control-schedule model.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] instr_in;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [2:0]  writenum;
  logic        vsel;
  logic        write;
  logic [15:0] datapath_in;
`ifdef DP_SEQ_ILLEGAL_FLAG_EN
  logic        ill_op;
`endif

  int n_vec = 0;
  int n_err = 0;

  dp_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .instr_in    (instr_in),
    .s           (s),
    .w           (w),
    .readnum     (readnum),
    .loada       (loada),
    .loadb       (loadb),
    .shift       (shift),
    .asel        (asel),
    .bsel        (bsel),
    .ALUop       (ALUop),
    .loadc       (loadc),
    .loads       (loads),
    .writenum    (writenum),
    .vsel        (vsel),
    .write       (write),
    .datapath_in (datapath_in)
`ifdef DP_SEQ_ILLEGAL_FLAG_EN
    ,
    .ill_op      (ill_op)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control vector layout: {w, readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, writenum, vsel, write}
  function automatic logic [18:0] mk(input logic wv, input logic [2:0] rn, input logic la, input logic lb,
                                     input logic [1:0] sh, input logic as, input logic [1:0] alu,
                                     input logic lc, input logic ls, input logic [2:0] wn,
                                     input logic vs, input logic wr);
    return {wv, rn, la, lb, sh, as, 1'b0, alu, lc, ls, wn, vs, wr};
  endfunction

  function automatic logic [18:0] obs();
    return {w, readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, writenum, vsel, write};
  endfunction

  function automatic logic [15:0] sext(input logic [15:0] ir);
    return {{8{ir[7]}}, ir[7:0]};
  endfunction

  // Expected controls at cycle cyc (1 = DECODE) of an instruction; returns cycles spent outside WAIT.
  function automatic int model(input logic [15:0] ir, input int cyc, output logic [18:0] v);
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [2:0]  n;
    logic [2:0]  d;
    logic [2:0]  m;
    logic [1:0]  sh;
    logic [18:0] st [0:5];
    int          len;
    opc = ir[15:13]; op = ir[12:11]; n = ir[10:8]; d = ir[7:5]; sh = ir[4:3]; m = ir[2:0];
    for (int i = 0; i < 6; i++) st[i] = '0;
    len = 1;
    if (opc == 3'b110 && op == 2'b10) begin          // MOV Rn,#imm8
      st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, n, 1, 1);
      len = 2;
    end else if (opc == 3'b110 && op == 2'b00) begin // MOV Rd,Rm
      st[1] = mk(0, m, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      st[2] = mk(0, 0, 0, 0, sh, 1, 2'b00, 1, 0, 0, 0, 0);
      st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, d, 0, 1);
      len = 4;
    end else if (opc == 3'b101 && op == 2'b11) begin // MVN
      st[1] = mk(0, m, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      st[2] = mk(0, 0, 0, 0, sh, 0, 2'b11, 1, 0, 0, 0, 0);
      st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, d, 0, 1);
      len = 4;
    end else if (opc == 3'b101 && op == 2'b01) begin // CMP
      st[1] = mk(0, n, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      st[2] = mk(0, m, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      st[3] = mk(0, 0, 0, 0, sh, 0, 2'b01, 0, 1, 0, 0, 0);
      len = 4;
    end else if (opc == 3'b101) begin                // ADD / AND
      st[1] = mk(0, n, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      st[2] = mk(0, m, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      st[3] = mk(0, 0, 0, 0, sh, 0, op, 1, 0, 0, 0, 0);
      st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, d, 0, 1);
      len = 5;
    end
    v = (cyc >= 1 && cyc <= len) ? st[cyc-1] : mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    return len;
  endfunction

  // junk: 0 none, 1 load 0xD0FD while busy, 2 random load/s while busy
  task automatic run_instr(input logic [15:0] ir, input int junk, input string name);
    logic [18:0] v;
    int          len;
    load = 1'b1; instr_in = ir; s = 1'b1;
    @(posedge clk); #1;
    len = model(ir, 1, v);
    for (int cyc = 1; cyc <= len + 1; cyc++) begin
      load = 1'b0; s = 1'b0;
      void'(model(ir, cyc, v));
      check_eq($sformatf("%s ctrl c%0d", name, cyc), 32'(obs()), 32'(v));
      check_eq($sformatf("%s dp_in c%0d", name, cyc), 32'(datapath_in), 32'(sext(ir)));
`ifdef DP_SEQ_ILLEGAL_FLAG_EN
      check_eq($sformatf("%s ill_op c%0d", name, cyc), 32'(ill_op), 32'(len == 1 && cyc >= 2));
`endif
      if (cyc <= len) begin
        if (junk == 1) begin
          load = 1'b1; instr_in = 16'hD0FD;
        end else if (junk == 2) begin
          load = 1'($urandom); instr_in = 16'($urandom); s = 1'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    load = 1'b0; s = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    logic [4:0]  tbl [0:5];
    int          k;
    tbl[0] = 5'b110_10; tbl[1] = 5'b110_00; tbl[2] = 5'b101_00;
    tbl[3] = 5'b101_01; tbl[4] = 5'b101_10; tbl[5] = 5'b101_11;
    r = 16'($urandom);
    k = int'($urandom_range(0, 7));
    if (k < 6) r[15:11] = tbl[k];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] v;
    rst_n = 1'b0; load = 1'b0; s = 1'b0; instr_in = '0;
    #12;
    check_eq("reset ctrl", 32'(obs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    check_eq("reset dp_in", 32'(datapath_in), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(16'hD0FD, 0, "mov_imm");
    run_instr(16'hA148, 0, "add");
    run_instr(16'hA900, 0, "cmp");
    run_instr(16'hC061, 1, "mov_reg");
    run_instr(16'hB86A, 2, "mvn");
    run_instr(16'hB2F7, 2, "and");
    run_instr(16'h0000, 0, "illegal");
    run_instr(16'hD37F, 0, "mov_imm_pos");

    // Abort mid-instruction: reset in EXEC must idle the controls immediately
    load = 1'b1; instr_in = 16'hA148; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    void'(model(16'hA148, 4, v));
    check_eq("abort exec ctrl", 32'(obs()), 32'(v));
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort ctrl", 32'(obs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    check_eq("abort dp_in", 32'(datapath_in), 32'h0);
`ifdef DP_SEQ_ILLEGAL_FLAG_EN
    check_eq("abort ill_op", 32'(ill_op), 32'h0);
`endif
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("post-abort idle %0d", i), 32'(obs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    end

    for (int i = 0; i < 80; i++) begin
      run_instr(rand_instr(), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
